object_compositor: RTL
======================

OBJECT_COMPOSITOR -- requirements
Module: object_compositor

Interface
REQ-001 Parameter NUM_OBJ, default 4: number of rectangular objects composited; legal range 1..8.
REQ-002 Parameter COORD_W, default 10: width of all coordinate and size fields.
REQ-003 Parameter BG_COLOR, default 8'b00011100: RRRGGGBB colour driven when no enabled object covers the pixel.
REQ-004 clk  in  1  pixel clock; all logic on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 wr_en  in  1  object-register write strobe, one write per cycle.
REQ-007 wr_obj  in  3  target object index; index >= NUM_OBJ ignored.
REQ-008 wr_field  in  3  0=X, 1=Y, 2=W, 3=H, 4={enable,color}; 5..7 ignored.
REQ-009 wr_data  in  COORD_W  write data; field 4 uses bit 8 = enable, bits 7:0 = colour.
REQ-010 frame_start  in  1  one-cycle pulse at the top of each frame; commits shadow registers.
REQ-011 inDisplayArea  in  1  current pixel is visible.
REQ-012 CounterX, CounterY  in  COORD_W each  current pixel coordinate.
REQ-013 vgaRed, vgaGreen, vgaBlue  out  3 each  registered pixel colour.
REQ-014 hit_vec  out  NUM_OBJ  registered per-object coverage of the pixel, aligned with the RGB outputs.
REQ-015 collide_vec  out  NUM_OBJ  per-object overlap flags for the previous completed frame.

Function
REQ-016 Each object SHALL have shadow registers X, Y, W, H, colour and enable; writes update only the shadow set.
REQ-017 On frame_start the active set SHALL load the shadow set in full; a write in the same cycle SHALL be included in the committed values.
REQ-018 Active registers SHALL change only on frame_start or reset, so no mid-frame tearing is possible.
REQ-019 Coverage test: enabled AND X <= CounterX < X+W AND Y <= CounterY < Y+H, with sums computed at COORD_W+1 bits (no wrap); W=0 or H=0 never covers.
REQ-020 Stage 1 SHALL register the per-object coverage and inDisplayArea; stage 2 SHALL register the RGB outputs and hit_vec; latency from the counters to the RGB outputs is exactly 2 cycles.
REQ-021 Priority: the lowest-index covering object wins.
REQ-022 Colour mapping: Red = c[7:5], Green = c[4:2], Blue = {c[1:0], 1'b0}.
REQ-023 When the delayed inDisplayArea is 0, RGB and hit_vec SHALL be 0.
REQ-024 When visible with no coverage, RGB SHALL be derived from BG_COLOR by REQ-022.
REQ-025 Collision accumulator: when a visible pixel has 2 or more covering objects, the accumulator bit of every covering object SHALL be set (sticky).
REQ-026 On frame_start, collide_vec SHALL load the accumulator OR the current stage-1 collisions, and the accumulator SHALL clear in the same cycle.
REQ-027 Out-of-range wr_obj or wr_field SHALL leave all state unchanged.

Reset
REQ-028 Reset SHALL clear all shadow and active registers (all objects disabled), pipeline stages, accumulator, RGB, hit_vec and collide_vec to 0.
REQ-029 Reset SHALL take priority over frame_start and wr_en in the same cycle.
REQ-030 The first visible pixel after reset SHALL show BG_COLOR and no collisions.

Verification
REQ-031 Write obj0 X=100, Y=100, W=300, H=100, {1, 8'hE0}; pulse frame_start; pixel (100,100) visible -> 2 cycles later RGB = 7,0,0 and hit_vec = 0001; pixel (400,100) -> background 0,7,0.
REQ-032 Write new X to obj0 mid-frame without frame_start -> rendering is unchanged until the next frame_start, then the new X is used.
REQ-033 Overlap obj0 (red) and obj1 (white) at (120,120) -> RGB = 7,0,0, hit_vec = 0011; after the next frame_start collide_vec = 0011.
REQ-034 inDisplayArea = 0 while the pixel is inside obj0 -> RGB = 0,0,0 and hit_vec = 0; no collision accumulated.
REQ-035 Object at X=1000, W=100 (COORD_W = 10) -> no wrap; pixel X=50 is not covered; W=0 is never covered.
REQ-036 Assert reset together with frame_start and wr_en after configuring objects -> next cycle all outputs are 0 and all objects disabled.

Source files
------------

// File: rtl/object_compositor.sv
// object_compositor: double-buffered rectangle sprites composited into a 2-stage RGB pixel pipeline
// with per-frame collision flags.
module object_compositor #(
    parameter int          NUM_OBJ  = 4,
    parameter int          COORD_W  = 10,
    parameter logic [7:0]  BG_COLOR = 8'b00011100
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [2:0]          wr_obj,
    input  logic [2:0]          wr_field,
    input  logic [COORD_W-1:0]  wr_data,
    input  logic                frame_start,
    input  logic                inDisplayArea,
    input  logic [COORD_W-1:0]  CounterX,
    input  logic [COORD_W-1:0]  CounterY,
    output logic [2:0]          vgaRed,
    output logic [2:0]          vgaGreen,
    output logic [2:0]          vgaBlue,
    output logic [NUM_OBJ-1:0]  hit_vec,
    output logic [NUM_OBJ-1:0]  collide_vec
);
    typedef struct packed {
        logic               en;
        logic [7:0]         c;
        logic [COORD_W-1:0] h;
        logic [COORD_W-1:0] w;
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] x;
    } obj_t;

    obj_t               r_sh  [NUM_OBJ];
    obj_t               r_act [NUM_OBJ];
    obj_t               w_nsh [NUM_OBJ];
    logic [NUM_OBJ-1:0] w_cov;
    logic [NUM_OBJ-1:0] w_col;
    logic [NUM_OBJ-1:0] r_cov;
    logic [NUM_OBJ-1:0] r_acc;
    logic               r_vis;
    logic [7:0]         w_c;

    // Shadow set with this cycle's write folded in, so a commit in the same cycle sees it.
    always_comb begin
        for (int i = 0; i < NUM_OBJ; i++) begin
            w_nsh[i] = r_sh[i];
            if (wr_en && wr_obj == 3'(i)) begin
                case (wr_field)
                    3'd0: w_nsh[i].x = wr_data;
                    3'd1: w_nsh[i].y = wr_data;
                    3'd2: w_nsh[i].w = wr_data;
                    3'd3: w_nsh[i].h = wr_data;
                    3'd4: {w_nsh[i].en, w_nsh[i].c} = wr_data[8:0];
                    default: ;
                endcase
            end
        end
    end

    // Upper bounds are formed one bit wider so X+W past the screen edge never wraps.
    always_comb begin
        w_cov = '0;
        for (int i = 0; i < NUM_OBJ; i++)
            w_cov[i] = r_act[i].en
                && CounterX >= r_act[i].x
                && {1'b0, CounterX} < {1'b0, r_act[i].x} + {1'b0, r_act[i].w}
                && CounterY >= r_act[i].y
                && {1'b0, CounterY} < {1'b0, r_act[i].y} + {1'b0, r_act[i].h};
    end

    assign w_col = (r_vis && |(r_cov & (r_cov - 1'b1))) ? r_cov : '0;

    always_comb begin
        w_c = BG_COLOR;
        for (int i = NUM_OBJ - 1; i >= 0; i--)
            if (r_cov[i]) w_c = r_act[i].c;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_OBJ; i++) begin
                r_sh[i]  <= '0;
                r_act[i] <= '0;
            end
            r_cov       <= '0;
            r_vis       <= 1'b0;
            r_acc       <= '0;
            collide_vec <= '0;
            hit_vec     <= '0;
            vgaRed      <= '0;
            vgaGreen    <= '0;
            vgaBlue     <= '0;
        end else begin
            for (int i = 0; i < NUM_OBJ; i++) begin
                r_sh[i] <= w_nsh[i];
                if (frame_start) r_act[i] <= w_nsh[i];
            end
            r_cov <= w_cov;
            r_vis <= inDisplayArea;
            r_acc <= frame_start ? '0 : (r_acc | w_col);
            if (frame_start) collide_vec <= r_acc | w_col;
            hit_vec  <= r_vis ? r_cov : '0;
            vgaRed   <= r_vis ? w_c[7:5] : 3'd0;
            vgaGreen <= r_vis ? w_c[4:2] : 3'd0;
            vgaBlue  <= r_vis ? {w_c[1:0], 1'b0} : 3'd0;
        end
    end
endmodule
